// File: rtl/shadow_vram_pkg.sv
// Shared types and constants for the shadow-video BSRAM read arbiter.
package shadow_vram_pkg;

  localparam int unsigned MAX_REQ      = 4;
  localparam int unsigned TAG_W        = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/vram_tag_pipe.sv
// Delay line carrying {valid, requester index} alongside the BSRAM read latency.
module vram_tag_pipe
  import shadow_vram_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [READ_LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < READ_LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < READ_LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/shadow_vram_arbiter.sv
// One-read-per-clock arbiter for a shadow-video BSRAM port: fixed priority for
// requester 0, round-robin for the rest, starvation guard and tagged responses.
module shadow_vram_arbiter
  import shadow_vram_pkg::*;
#(
  parameter int unsigned N_REQ        = 3,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                        clk_logic,
  input  logic                        system_reset,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]       rsp_data_o,
  output logic                        mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0]       mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]       mem_rd_data_i,
  output logic                        starve_o
);

  localparam int unsigned RR_N = (N_REQ > 1) ? N_REQ - 1 : 1;
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] wait_q [N_REQ];
  logic [STARVE_CNT_W-1:0] wait_d [N_REQ];
  logic [TAG_W-1:0]        rr_q, rr_d;
  logic                    starve_q, starve_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [N_REQ-1:0]        gnt;
  logic [TAG_W-1:0]        gnt_idx;
  logic                    found;
  logic                    forced;
  int unsigned             cand;
  rd_tag_t                 tag_in, tag_out;

  // Grant selection: starvation first, then requester 0, then round-robin.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    forced  = 1'b0;
    cand    = 0;
    for (int unsigned k = 1; k < N_REQ; k++) begin
      if (!found && req_valid_i[k] && wait_q[k] == LIMIT) begin
        found   = 1'b1;
        forced  = 1'b1;
        gnt_idx = TAG_W'(k);
      end
    end
    if (!found && req_valid_i[0]) begin
      found   = 1'b1;
      gnt_idx = '0;
    end
    // Walk rr_ptr+1 .. with wrap over indices 1..N_REQ-1 only.
    for (int unsigned off = 1; off < N_REQ; off++) begin
      cand = ((int'(rr_q) + RR_N - 1 + off) % RR_N) + 1;
      if (!found && req_valid_i[cand]) begin
        found   = 1'b1;
        gnt_idx = TAG_W'(cand);
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready_o   = gnt;
  assign mem_rd_en_o   = found;
  assign mem_rd_addr_o = found ? req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH]
                               : '0;

  always_comb begin
    wait_d[0] = '0;
    for (int unsigned k = 1; k < N_REQ; k++) begin
      if (!req_valid_i[k] || gnt[k]) begin
        wait_d[k] = '0;
      end else if (wait_q[k] != LIMIT) begin
        wait_d[k] = wait_q[k] + 1'b1;
      end else begin
        wait_d[k] = wait_q[k];
      end
    end
    rr_d     = (found && gnt_idx != '0) ? gnt_idx : rr_q;
    starve_d = forced;
  end

  assign tag_in = '{valid: found, idx: gnt_idx};

  vram_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clk_i (clk_logic),
    .rst_i (system_reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_out.valid) begin
      rsp_valid_d[tag_out.idx] = 1'b1;
      rsp_data_d               = mem_rd_data_i;
    end
  end

  always_ff @(posedge clk_logic or posedge system_reset) begin
    if (system_reset) begin
      for (int unsigned k = 0; k < N_REQ; k++) wait_q[k] <= '0;
      rr_q        <= TAG_W'(N_REQ - 1);
      starve_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) wait_q[k] <= wait_d[k];
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign starve_o    = starve_q;

endmodule

// File: tb/tb_shadow_vram_arbiter.sv
// Directed bench for shadow_vram_arbiter at READ_LATENCY 1 and 3 sharing one stimulus.
module tb_shadow_vram_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;

  typedef struct {
    int unsigned   due;
    logic [N-1:0]  oh;
    logic [DW-1:0] data;
  } sb_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [AW-1:0]   addr [N];
  logic [N*AW-1:0] req_addr;

  logic [N-1:0]    ready1, rv1, ready3, rv3;
  logic [DW-1:0]   rd1, rd3, m1, m3_0, m3_1, m3_2;
  logic            en1, en3, st1, st3;
  logic [AW-1:0]   ma1, ma3;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc_n = 0;
  sb_t q1[$], q3[$];
  sb_t e1, e3;

  assign req_addr = {addr[2], addr[1], addr[0]};

  always #5 clk = ~clk;

  shadow_vram_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .STARVE_LIMIT(8)
  ) dut1 (
    .clk_logic(clk), .system_reset(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(ready1), .rsp_valid_o(rv1), .rsp_data_o(rd1), .mem_rd_en_o(en1),
    .mem_rd_addr_o(ma1), .mem_rd_data_i(m1), .starve_o(st1)
  );

  shadow_vram_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3), .STARVE_LIMIT(8)
  ) dut3 (
    .clk_logic(clk), .system_reset(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_ready_o(ready3), .rsp_valid_o(rv3), .rsp_data_o(rd3), .mem_rd_en_o(en3),
    .mem_rd_addr_o(ma3), .mem_rd_data_i(m3_2), .starve_o(st3)
  );

  // BSRAM models: data = address + 0x1000 after 1 or 3 clocks.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    m1    <= 32'(ma1) + 32'h1000;
    m3_0  <= 32'(ma3) + 32'h1000;
    m3_1  <= m3_0;
    m3_2  <= m3_1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    if (q1.size() != 0 && q1[0].due == cyc_n) begin
      e1 = q1.pop_front();
      chk("l1_rsp_valid", 32'(rv1), 32'(e1.oh));
      chk("l1_rsp_data", rd1, e1.data);
    end else begin
      chk("l1_rsp_idle", 32'(rv1), 32'h0);
    end
    if (q3.size() != 0 && q3[0].due == cyc_n) begin
      e3 = q3.pop_front();
      chk("l3_rsp_valid", 32'(rv3), 32'(e3.oh));
      chk("l3_rsp_data", rd3, e3.data);
    end else begin
      chk("l3_rsp_idle", 32'(rv3), 32'h0);
    end
  end

  // One clock of stimulus; called #1 after a rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] g, input logic s);
    logic [AW-1:0] ea;
    req_valid = v;
    #1;
    ea = '0;
    for (int k = 0; k < N; k++) if (g[k]) ea = addr[k];
    chk("l1_ready", 32'(ready1), 32'(g));
    chk("l3_ready", 32'(ready3), 32'(g));
    chk("rd_en", 32'(en1), 32'(|g));
    chk("rd_addr", 32'(ma1), 32'(ea));
    chk("l1_starve", 32'(st1), 32'(s));
    chk("l3_starve", 32'(st3), 32'(s));
    if (|g) begin
      q1.push_back('{due: cyc_n + 2, oh: g, data: 32'(ea) + 32'h1000});
      q3.push_back('{due: cyc_n + 4, oh: g, data: 32'(ea) + 32'h1000});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    q1.delete();
    q3.delete();
    #1;
    chk("rst_rsp_valid", 32'(rv1 | rv3), 32'h0);
    chk("rst_rsp_data1", rd1, 32'h0);
    chk("rst_rsp_data3", rd3, 32'h0);
    chk("rst_starve", 32'(st1 | st3), 32'h0);
    chk("rst_ready", 32'(ready1 | ready3), 32'h0);
    chk("rst_rd_en", 32'(en1 | en3), 32'h0);
    chk("rst_rd_addr", 32'(ma1), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    addr[0] = 13'h0010;
    addr[1] = 13'h0123;
    addr[2] = 13'h0300;
    do_reset();

    // Single read from requester 1.
    step(3'b010, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b000, 3'b000, 1'b0);

    // Round-robin between 1 and 2 from reset.
    do_reset();
    addr[1] = 13'h0200;
    for (int i = 0; i < 6; i++) step(3'b110, (i % 2 == 0) ? 3'b010 : 3'b100, 1'b0);

    // Requester 2 starved under requester-0 load: forced grant every 9th cycle.
    for (int i = 0; i < 19; i++)
      step(3'b101, (i % 9 == 8) ? 3'b100 : 3'b001, (i == 9 || i == 18));

    // Requester 1 drops after 5 denied cycles: counter restarts.
    addr[1] = 13'h0111;
    for (int i = 0; i < 5; i++) step(3'b011, 3'b001, 1'b0);
    step(3'b001, 3'b001, 1'b0);
    for (int i = 0; i < 8; i++) step(3'b011, 3'b001, 1'b0);
    step(3'b011, 3'b010, 1'b0);
    step(3'b001, 3'b001, 1'b1);

    // Back-to-back 0,1,2,0 with responses in order.
    step(3'b001, 3'b001, 1'b0);
    step(3'b010, 3'b010, 1'b0);
    step(3'b100, 3'b100, 1'b0);
    step(3'b001, 3'b001, 1'b0);
    for (int i = 0; i < 5; i++) step(3'b000, 3'b000, 1'b0);

    // Reset with reads in flight: nothing emerges afterwards.
    step(3'b001, 3'b001, 1'b0);
    step(3'b010, 3'b010, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) step(3'b000, 3'b000, 1'b0);

    chk("sb_drain1", q1.size(), 32'h0);
    chk("sb_drain3", q3.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
